param_add_acc: RTL and testbench

//  Parametrised, handshaked add/accumulate unit: successor to the fixed 4-bit registered adder.

---
 rtl/add_acc_pkg.sv | 10 +
 rtl/param_add_acc_if.sv | 27 ++
 rtl/sat_counter.sv | 22 ++
 rtl/param_add_acc.sv | 77 +++++++
 tb/tb_param_add_acc.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/add_acc_pkg.sv
// Shared mode encodings and handshake FSM state type for the add/accumulate unit.
package add_acc_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/param_add_acc_if.sv
// Operand/result handshake bundle between producer, add/accumulate unit and consumer.
interface param_add_acc_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             overflow;
  logic [CNT_W-1:0] ovf_count;

  modport master (
    output in_valid, a, b, mode, clear, out_ready,
    input  in_ready, out_valid, sum, overflow, ovf_count
  );

  modport slave (
    input  in_valid, a, b, mode, clear, out_ready,
    output in_ready, out_valid, sum, overflow, ovf_count
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter; a clear coinciding with an event restarts the count at one.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= CNT_W'(inc);
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/param_add_acc.sv
// Handshaked add/accumulate unit with registered result, carry flag and overflow event count.
// Optional clamping of the result on carry when SATURATE_EN is defined.
module param_add_acc
  import add_acc_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  param_add_acc_if.slave  bus
);
  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic [WIDTH:0]   raw;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             accept;

  assign bus.in_ready = (state == ST_EMPTY) | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  // A clear arriving with a beat makes that beat accumulate from zero.
  always_comb begin
    acc_eff = bus.clear ? '0 : acc;
    op_x    = bus.a;
    op_y    = bus.b;
    if (bus.mode != MODE_ADD) begin
      op_x = acc_eff;
      op_y = bus.a;
    end
    raw   = {1'b0, op_x} + {1'b0, op_y};
    carry = raw[WIDTH];
`ifdef SATURATE_EN
    res   = carry ? '1 : raw[WIDTH-1:0];
`else
    res   = raw[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_EMPTY;
      bus.out_valid <= 1'b0;
      bus.sum       <= '0;
      bus.overflow  <= 1'b0;
      acc           <= '0;
    end else begin
      if (accept) begin
        state         <= ST_FULL;
        bus.out_valid <= 1'b1;
        bus.sum       <= res;
        bus.overflow  <= carry;
        acc           <= res;
      end else begin
        if ((state == ST_FULL) && bus.out_ready) begin
          state         <= ST_EMPTY;
          bus.out_valid <= 1'b0;
        end
        if (bus.clear) begin
          acc <= '0;
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clear),
    .inc   (accept & carry),
    .count (bus.ovf_count)
  );
endmodule

// File: tb/tb_param_add_acc.sv
// Scoreboard bench for param_add_acc: directed beats push expected results, monitors pop on transfer.
module tb_param_add_acc;
  import add_acc_pkg::*;

`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [3:0] s;
    logic       o;
    logic [7:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  param_add_acc_if #(.WIDTH(4), .CNT_W(8)) i1 ();
  param_add_acc_if #(.WIDTH(4), .CNT_W(2)) i2 ();

  param_add_acc #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(i1.slave));
  param_add_acc #(.WIDTH(4), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(i2.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives one beat into DUT 1 (which=0) or DUT 2 (which=1) and waits for acceptance.
  task automatic send(input bit which, input logic [3:0] av, input logic [3:0] bv,
                      input logic md, input logic clr, input bit push,
                      input logic [3:0] es, input logic eo, input logic [7:0] ec);
    exp_t e;
    int   n;
    e.s = es; e.o = eo; e.c = ec;
    if (push) begin
      if (which) q2.push_back(e);
      else       q1.push_back(e);
    end
    if (which) begin
      i2.in_valid = 1'b1; i2.a = av; i2.b = bv; i2.mode = md; i2.clear = clr;
    end else begin
      i1.in_valid = 1'b1; i1.a = av; i1.b = bv; i1.mode = md; i1.clear = clr;
    end
    n = 0;
    @(negedge clk);
    while (!(which ? i2.in_ready : i1.in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 32'(n), 32'(0));
    @(posedge clk);
    #1;
    if (which) begin
      i2.in_valid = 1'b0; i2.clear = 1'b0;
    end else begin
      i1.in_valid = 1'b0; i1.clear = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && i1.out_valid && i1.out_ready) begin
      if (q1.size() == 0) begin
        chk("mon1_unexpected", 32'(1), 32'(0));
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("mon1_sum", 32'(i1.sum), 32'(e.s));
        chk("mon1_ovf", 32'(i1.overflow), 32'(e.o));
        chk("mon1_cnt", 32'(i1.ovf_count), 32'(e.c));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && i2.out_valid && i2.out_ready) begin
      if (q2.size() == 0) begin
        chk("mon2_unexpected", 32'(1), 32'(0));
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("mon2_sum", 32'(i2.sum), 32'(e.s));
        chk("mon2_ovf", 32'(i2.overflow), 32'(e.o));
        chk("mon2_cnt", 32'(i2.ovf_count), 32'(e.c));
      end
    end
  end

  initial begin
    i1.in_valid = 1'b0; i1.a = '0; i1.b = '0; i1.mode = MODE_ADD; i1.clear = 1'b0; i1.out_ready = 1'b1;
    i2.in_valid = 1'b0; i2.a = '0; i2.b = '0; i2.mode = MODE_ADD; i2.clear = 1'b0; i2.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(i1.out_valid), 32'(0));
    chk("rst_sum", 32'(i1.sum), 32'(0));
    chk("rst_ovf", 32'(i1.overflow), 32'(0));
    chk("rst_cnt", 32'(i1.ovf_count), 32'(0));
    chk("rst_in_ready", 32'(i1.in_ready), 32'(1));
    @(posedge clk); #1;

    // 1: F+F carries
    send(0, 4'hF, 4'hF, MODE_ADD, 0, 1, SAT ? 4'hF : 4'hE, 1'b1, 8'd1);
    // 2: back-to-back adds
    send(0, 4'h3, 4'h3, MODE_ADD, 0, 1, 4'h6, 1'b0, 8'd1);
    chk("b2b_in_ready", 32'(i1.in_ready), 32'(1));
    send(0, 4'hC, 4'hC, MODE_ADD, 0, 1, SAT ? 4'hF : 4'h8, 1'b1, 8'd2);
    repeat (2) @(posedge clk);
    #1;

    // 3: clear alone, then four accumulate beats
    i1.clear = 1'b1;
    @(posedge clk); #1 i1.clear = 1'b0;
    @(negedge clk);
    chk("clr_cnt", 32'(i1.ovf_count), 32'(0));
    chk("clr_keeps_sum", 32'(i1.sum), 32'(SAT ? 4'hF : 4'h8));
    chk("clr_keeps_ovf", 32'(i1.overflow), 32'(1));
    chk("clr_keeps_valid", 32'(i1.out_valid), 32'(0));
    @(posedge clk); #1;
    send(0, 4'h5, 4'h0, MODE_ACC, 0, 1, 4'h5, 1'b0, 8'd0);
    send(0, 4'h5, 4'h0, MODE_ACC, 0, 1, 4'hA, 1'b0, 8'd0);
    send(0, 4'h5, 4'h0, MODE_ACC, 0, 1, 4'hF, 1'b0, 8'd0);
    send(0, 4'h5, 4'h0, MODE_ACC, 0, 1, SAT ? 4'hF : 4'h4, 1'b1, 8'd1);
    repeat (2) @(posedge clk);
    #1;

    // 4: backpressure
    i1.out_ready = 1'b0;
    send(0, 4'h9, 4'h9, MODE_ADD, 0, 1, SAT ? 4'hF : 4'h2, 1'b1, 8'd2);
    fork
      send(0, 4'hA, 4'hA, MODE_ADD, 0, 1, SAT ? 4'hF : 4'h4, 1'b1, 8'd3);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(i1.in_ready), 32'(0));
          chk("bp_valid", 32'(i1.out_valid), 32'(1));
          chk("bp_sum_stable", 32'(i1.sum), 32'(SAT ? 4'hF : 4'h2));
          chk("bp_cnt_stable", 32'(i1.ovf_count), 32'(2));
        end
        @(posedge clk);
        #1 i1.out_ready = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // 5: two-bit counter saturates, clear with overflowing beat restarts at one
    send(1, 4'hF, 4'hF, MODE_ADD, 0, 1, SAT ? 4'hF : 4'hE, 1'b1, 8'd1);
    send(1, 4'hF, 4'hF, MODE_ADD, 0, 1, SAT ? 4'hF : 4'hE, 1'b1, 8'd2);
    send(1, 4'hF, 4'hF, MODE_ADD, 0, 1, SAT ? 4'hF : 4'hE, 1'b1, 8'd3);
    send(1, 4'hF, 4'hF, MODE_ADD, 0, 1, SAT ? 4'hF : 4'hE, 1'b1, 8'd3);
    send(1, 4'hF, 4'hF, MODE_ADD, 0, 1, SAT ? 4'hF : 4'hE, 1'b1, 8'd3);
    send(1, 4'hF, 4'hF, MODE_ADD, 1, 1, SAT ? 4'hF : 4'hE, 1'b1, 8'd1);
    repeat (2) @(posedge clk);
    #1;

    // 6: reset while holding a result under backpressure
    i1.out_ready = 1'b0;
    send(0, 4'h1, 4'h2, MODE_ADD, 0, 0, 4'h3, 1'b0, 8'd3);
    @(negedge clk);
    chk("pre_rst_sum", 32'(i1.sum), 32'(3));
    chk("pre_rst_valid", 32'(i1.out_valid), 32'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(i1.out_valid), 32'(0));
    chk("mid_rst_sum", 32'(i1.sum), 32'(0));
    chk("mid_rst_ovf", 32'(i1.overflow), 32'(0));
    chk("mid_rst_cnt", 32'(i1.ovf_count), 32'(0));
    chk("mid_rst_in_ready", 32'(i1.in_ready), 32'(1));
    @(posedge clk); #1;
    i1.out_ready = 1'b1;
    send(0, 4'h1, 4'h0, MODE_ACC, 0, 1, 4'h1, 1'b0, 8'd0);

    repeat (4) @(posedge clk);
    chk("q1_drained", 32'(q1.size()), 32'(0));
    chk("q2_drained", 32'(q2.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
